// File: rtl/el2_ifu_fetch_seq_ctl.sv
// el2_ifu_fetch_seq_ctl
//   IFU fetch sequencer. Picks the BF-stage fetch address (flush, boot,
//   replay, BTB target or sequential), registers it into the F stage, tracks
//   modelled fetch-buffer occupancy and raises the PMU fetch-stall event.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   ic_hit_f                 I-cache/ICCM hit for the F-stage request
//   ifu_ic_mb_empty          miss buffer empty (refill done)
//   fb_consume_cnt           entries freed by the aligner this cycle
//   exu_flush_final          flush, redirect to exu_flush_path_final [31:1]
//   dec_tlu_flush_noredir    flush without redirect (goes IDLE with a flush)
//   ifu_bp_hit_taken_f       BTB taken, target ifu_bp_btb_target_f [31:1]
//   stall_req                any bit set blocks the BF request
//   stall_cnt_clr            clears the stall counter
//   ifc_fetch_addr_bf        BF fetch address [31:1]
//   ifc_fetch_req_bf_raw     sequencer not IDLE (clock-gating hint)
//   ifc_fetch_req_bf         qualified BF request
//   ifc_fetch_addr_f/req_f   registered F-stage address and request
//   ifc_fb_occ               modelled fetch-buffer occupancy
//   ifc_state                00 IDLE, 01 FETCH, 11 WFM (wait for miss)
//   ifu_pmu_fetch_stall      PMU fetch-stall event
//   ifc_stall_cnt            stall-cycle count
//
// Configuration macro EL2_IFC_STALL_CNT_EN: when defined, ifc_stall_cnt is a
// saturating 16-bit count of cycles with ifu_pmu_fetch_stall set, cleared by
// stall_cnt_clr. When undefined the counter does not exist and reads 0.
//
// Handshake: ifc_fetch_req_bf is a one-cycle request qualified in the same
// cycle; it is registered into ifc_fetch_req_f, and the F-stage result comes
// back one cycle later on ic_hit_f. A request that misses is replayed from
// ifc_fetch_addr_f.
module el2_ifu_fetch_seq_ctl #(
   parameter int          FB_DEPTH    = 4,
   parameter int          FETCH_BYTES = 4,
   parameter int          LINE_BYTES  = 64,
   parameter int          MAX_CONSUME = 2,
   parameter int          NUM_STALL   = 3,
   parameter logic [31:0] RESET_VEC   = 32'h8000_0000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ic_hit_f,
   input  logic                               ifu_ic_mb_empty,
   input  logic [$clog2(MAX_CONSUME+1)-1:0]   fb_consume_cnt,
   input  logic                               exu_flush_final,
   input  logic [30:0]                        exu_flush_path_final,
   input  logic                               dec_tlu_flush_noredir,
   input  logic                               ifu_bp_hit_taken_f,
   input  logic [30:0]                        ifu_bp_btb_target_f,
   input  logic [NUM_STALL-1:0]               stall_req,
   input  logic                               stall_cnt_clr,
   output logic [30:0]                        ifc_fetch_addr_bf,
   output logic                               ifc_fetch_req_bf_raw,
   output logic                               ifc_fetch_req_bf,
   output logic [30:0]                        ifc_fetch_addr_f,
   output logic                               ifc_fetch_req_f,
   output logic [$clog2(FB_DEPTH+1)-1:0]      ifc_fb_occ,
   output logic [1:0]                         ifc_state,
   output logic                               ifu_pmu_fetch_stall,
   output logic [15:0]                        ifc_stall_cnt
);

   localparam int OW  = $clog2(FB_DEPTH+1);
   localparam int CW  = $clog2(MAX_CONSUME+1);
   localparam int SW  = ((OW > CW) ? OW : CW) + 2;
   // Address is held as [31:1], so the fetch-granule LSB sits one lower.
   localparam int SH  = $clog2(FETCH_BYTES) - 1;
   localparam logic [30:0] RESET_ADDR = RESET_VEC[31:1];

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      WFM   = 2'b11
   } state_t;

   state_t         state_q, state_ns;
   logic           boot_q;
   logic           miss_a_q;
   logic           flush, stall_any, miss_f, fill_f;
   logic [30:0]    seq_addr;
   logic [SW-1:0]  occ_add, occ_diff, consume_w;
   logic           occ_underflow;
   logic [OW-1:0]  occ_ns;
   logic           fb_full_ns;

   // Line size only constrains the address pattern; sequential increments
   // cross line boundaries without special handling.
   logic unused_line_ok;
   assign unused_line_ok = (LINE_BYTES >= FETCH_BYTES);

   assign flush     = exu_flush_final;
   assign stall_any = |stall_req;
   assign miss_f    = ifc_fetch_req_f & ~ic_hit_f & ~flush;
   assign fill_f    = ifc_fetch_req_f & ~miss_f;

   // Next fetch granule; 31-bit arithmetic wraps past the top of memory.
   assign seq_addr = ((ifc_fetch_addr_f >> SH) + 31'd1) << SH;

   always_comb begin
      ifc_fetch_addr_bf = seq_addr;
      if (flush)                             ifc_fetch_addr_bf = exu_flush_path_final;
      else if (boot_q)                       ifc_fetch_addr_bf = RESET_ADDR;
      else if (~ifc_fetch_req_f | ~ic_hit_f) ifc_fetch_addr_bf = ifc_fetch_addr_f;
      else if (ifu_bp_hit_taken_f)           ifc_fetch_addr_bf = ifu_bp_btb_target_f;
   end

   // Occupancy: add the F-stage fill, subtract aligner consumption, clamp.
   always_comb begin
      occ_add       = SW'(ifc_fb_occ) + SW'(fill_f);
      consume_w     = SW'(fb_consume_cnt);
      occ_diff      = occ_add - consume_w;
      occ_underflow = ~flush & (occ_add < consume_w);
      occ_ns        = occ_diff[OW-1:0];
      if (flush | occ_underflow)        occ_ns = '0;
      else if (occ_diff > SW'(FB_DEPTH)) occ_ns = OW'(FB_DEPTH);
   end

   assign fb_full_ns = (occ_ns == OW'(FB_DEPTH)) & (fb_consume_cnt == '0);

   assign ifc_fetch_req_bf_raw = (state_q != IDLE);
   assign ifc_fetch_req_bf     = ifc_fetch_req_bf_raw & ~fb_full_ns & ~stall_any &
                                 ~dec_tlu_flush_noredir;
   assign ifu_pmu_fetch_stall  = (state_q == WFM) |
                                 (ifc_fetch_req_bf_raw &
                                  (((ifc_fb_occ == OW'(FB_DEPTH)) & (fb_consume_cnt == '0) & ~flush) |
                                   stall_any));
   assign ifc_state = state_q;

   // Next-state logic. miss_f already excludes flush, so a flush in the same
   // cycle as a miss never enters WFM.
   always_comb begin
      state_ns = state_q;
      if (flush & dec_tlu_flush_noredir) begin
         state_ns = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (flush | boot_q) state_ns = FETCH;
            FETCH:   if (miss_f) state_ns = WFM;
            WFM:     if ((ifu_ic_mb_empty | flush) & ~stall_any & ~miss_f & ~miss_a_q)
                        state_ns = FETCH;
            default: state_ns = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         boot_q           <= 1'b1;
         miss_a_q         <= 1'b0;
         ifc_fetch_addr_f <= RESET_ADDR;
         ifc_fetch_req_f  <= 1'b0;
         ifc_fb_occ       <= '0;
      end else begin
         state_q         <= state_ns;
         boot_q          <= 1'b0;
         miss_a_q        <= miss_f;
         ifc_fetch_req_f <= ifc_fetch_req_bf;
         ifc_fb_occ      <= occ_ns;
         if (flush | ifc_fetch_req_f | boot_q)
            ifc_fetch_addr_f <= ifc_fetch_addr_bf;
      end
   end

`ifndef SYNTHESIS
   // The aligner must never free more entries than are present.
   occ_underflow_chk: assert property (@(posedge clk) disable iff (rst) !occ_underflow);
`endif

`ifdef EL2_IFC_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    stall_cnt_q <= '0;
      else if (stall_cnt_clr)                     stall_cnt_q <= '0;
      else if (ifu_pmu_fetch_stall & ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 16'd1;
   end
   assign ifc_stall_cnt = stall_cnt_q;
`else
   logic unused_stall_cnt_clr;
   assign unused_stall_cnt_clr = stall_cnt_clr;
   assign ifc_stall_cnt        = '0;
`endif

endmodule

// File: tb/tb_el2_ifu_fetch_seq_ctl.sv
// Bench for el2_ifu_fetch_seq_ctl: a driver issues one set of inputs per
// cycle and pushes the reference model's expected outputs; a monitor pops
// and compares them against the DUT. The model works on 32-bit byte
// addresses and integer occupancy.
module tb_el2_ifu_fetch_seq_ctl;

   localparam int          FB_DEPTH    = 4;
   localparam int          FETCH_BYTES = 4;
   localparam int          MAX_CONSUME = 2;
   localparam logic [31:0] RESET_VEC   = 32'h8000_0000;
   localparam int S_IDLE = 0, S_FETCH = 1, S_WFM = 3;

   typedef struct packed {
      logic [30:0] addr_bf;
      logic        raw;
      logic        req_bf;
      logic [30:0] addr_f;
      logic        req_f;
      logic [2:0]  occ;
      logic [1:0]  st;
      logic        pmu;
      logic [15:0] cnt;
   } exp_t;

   logic        clk, rst;
   logic        ic_hit_f, ifu_ic_mb_empty, exu_flush_final, dec_tlu_flush_noredir;
   logic        ifu_bp_hit_taken_f, stall_cnt_clr;
   logic [1:0]  fb_consume_cnt;
   logic [30:0] exu_flush_path_final, ifu_bp_btb_target_f;
   logic [2:0]  stall_req;
   logic [30:0] ifc_fetch_addr_bf, ifc_fetch_addr_f;
   logic        ifc_fetch_req_bf_raw, ifc_fetch_req_bf, ifc_fetch_req_f, ifu_pmu_fetch_stall;
   logic [2:0]  ifc_fb_occ;
   logic [1:0]  ifc_state;
   logic [15:0] ifc_stall_cnt;

   el2_ifu_fetch_seq_ctl dut (
      .clk(clk), .rst(rst),
      .ic_hit_f(ic_hit_f), .ifu_ic_mb_empty(ifu_ic_mb_empty),
      .fb_consume_cnt(fb_consume_cnt),
      .exu_flush_final(exu_flush_final), .exu_flush_path_final(exu_flush_path_final),
      .dec_tlu_flush_noredir(dec_tlu_flush_noredir),
      .ifu_bp_hit_taken_f(ifu_bp_hit_taken_f), .ifu_bp_btb_target_f(ifu_bp_btb_target_f),
      .stall_req(stall_req), .stall_cnt_clr(stall_cnt_clr),
      .ifc_fetch_addr_bf(ifc_fetch_addr_bf), .ifc_fetch_req_bf_raw(ifc_fetch_req_bf_raw),
      .ifc_fetch_req_bf(ifc_fetch_req_bf), .ifc_fetch_addr_f(ifc_fetch_addr_f),
      .ifc_fetch_req_f(ifc_fetch_req_f), .ifc_fb_occ(ifc_fb_occ), .ifc_state(ifc_state),
      .ifu_pmu_fetch_stall(ifu_pmu_fetch_stall), .ifc_stall_cnt(ifc_stall_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // reference model state (byte addresses)
   int          m_st;
   logic        m_boot, m_req_f, m_miss_a;
   logic [31:0] m_addr_f;
   int          m_occ, m_cnt;

   // next-cycle stimulus
   logic        n_rst, n_hit, n_mb, n_fl, n_nr, n_bp, n_clr;
   logic [31:0] n_path, n_tgt;
   logic [2:0]  n_stall;
   int          n_cons;

   function automatic void model_reset();
      m_st = S_IDLE; m_boot = 1'b1; m_req_f = 1'b0; m_miss_a = 1'b0;
      m_addr_f = RESET_VEC; m_occ = 0; m_cnt = 0;
   endfunction

   task automatic defaults();
      n_rst = 1'b0; n_hit = 1'b1; n_mb = 1'b0; n_fl = 1'b0; n_nr = 1'b0; n_bp = 1'b0;
      n_clr = 1'b0; n_path = 32'h0; n_tgt = 32'h0; n_stall = 3'b000; n_cons = 1;
   endtask

   // driver: one cycle of stimulus plus its expected outputs
   task automatic tick();
      int          inc, cons, occ_ns, t, ns;
      logic        miss, stall, full, req_bf, pmu;
      logic [31:0] a_bf;
      exp_t        e;
      @(negedge clk);
      cyc++;
      stall = |n_stall;
      inc   = (m_req_f && n_hit) ? 1 : 0;
      cons  = n_cons;
      if (!n_fl && cons > m_occ + inc) cons = m_occ + inc;

      rst                   = n_rst;
      ic_hit_f              = n_hit;
      ifu_ic_mb_empty       = n_mb;
      exu_flush_final       = n_fl;
      exu_flush_path_final  = n_path[31:1];
      dec_tlu_flush_noredir = n_nr;
      ifu_bp_hit_taken_f    = n_bp;
      ifu_bp_btb_target_f   = n_tgt[31:1];
      stall_req             = n_stall;
      stall_cnt_clr         = n_clr;
      fb_consume_cnt        = 2'(cons);

      miss = m_req_f && !n_hit && !n_fl;
      if (n_fl)                   a_bf = n_path;
      else if (m_boot)            a_bf = RESET_VEC;
      else if (!m_req_f || !n_hit) a_bf = m_addr_f;
      else if (n_bp)              a_bf = n_tgt;
      else                        a_bf = (m_addr_f / FETCH_BYTES + 1) * FETCH_BYTES;

      if (n_fl) occ_ns = 0;
      else begin
         t = m_occ + ((m_req_f && !miss) ? 1 : 0) - cons;
         occ_ns = (t < 0) ? 0 : (t > FB_DEPTH) ? FB_DEPTH : t;
      end
      full   = (occ_ns == FB_DEPTH) && (cons == 0);
      req_bf = (m_st != S_IDLE) && !full && !stall && !n_nr;
      pmu    = (m_st == S_WFM) ||
               ((m_st != S_IDLE) && (((m_occ == FB_DEPTH) && (cons == 0) && !n_fl) || stall));

      e.addr_bf = a_bf[31:1];
      e.raw     = (m_st != S_IDLE);
      e.req_bf  = req_bf;
      e.addr_f  = m_addr_f[31:1];
      e.req_f   = m_req_f;
      e.occ     = 3'(m_occ);
      e.st      = 2'(m_st);
      e.pmu     = pmu;
      e.cnt     = 16'(m_cnt);
      exp_q.push_back(e);

      if (n_rst) begin
         model_reset();
      end else begin
         if (n_fl && n_nr)        ns = S_IDLE;
         else if (m_st == S_IDLE) ns = (n_fl || m_boot) ? S_FETCH : S_IDLE;
         else if (m_st == S_FETCH) ns = miss ? S_WFM : S_FETCH;
         else ns = ((n_mb || n_fl) && !stall && !miss && !m_miss_a) ? S_FETCH : S_WFM;
         if (n_fl || m_req_f || m_boot) m_addr_f = a_bf;
`ifdef EL2_IFC_STALL_CNT_EN
         if (n_clr) m_cnt = 0;
         else if (pmu && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
         m_st     = ns;
         m_boot   = 1'b0;
         m_req_f  = req_bf;
         m_miss_a = miss;
         m_occ    = occ_ns;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // monitor: compare each presented output set with the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("addr_bf",  {1'b0, ifc_fetch_addr_bf},  {1'b0, e.addr_bf});
            chk("req_raw",  32'(ifc_fetch_req_bf_raw), 32'(e.raw));
            chk("req_bf",   32'(ifc_fetch_req_bf),     32'(e.req_bf));
            chk("addr_f",   {1'b0, ifc_fetch_addr_f},   {1'b0, e.addr_f});
            chk("req_f",    32'(ifc_fetch_req_f),      32'(e.req_f));
            chk("occ",      32'(ifc_fb_occ),           32'(e.occ));
            chk("state",    32'(ifc_state),            32'(e.st));
            chk("pmu",      32'(ifu_pmu_fetch_stall),  32'(e.pmu));
            chk("stall_cnt", 32'(ifc_stall_cnt),       32'(e.cnt));
         end
      end
   end

   // stimulus sequence
   initial begin
      rst = 1'b1; ic_hit_f = 1'b0; ifu_ic_mb_empty = 1'b0; exu_flush_final = 1'b0;
      exu_flush_path_final = '0; dec_tlu_flush_noredir = 1'b0; ifu_bp_hit_taken_f = 1'b0;
      ifu_bp_btb_target_f = '0; stall_req = '0; stall_cnt_clr = 1'b0; fb_consume_cnt = '0;
      model_reset();

      // reset held, then sequential fetch across a line boundary
      defaults(); n_rst = 1'b1; n_cons = 0;
      repeat (3) tick();
      defaults();
      repeat (22) tick();

      // miss at 0x8000_0010, wait for refill, replay
      defaults(); n_fl = 1'b1; n_path = 32'h8000_0010; tick();
      defaults(); n_hit = 1'b0; repeat (3) tick();
      defaults(); n_mb = 1'b1; repeat (2) tick();
      defaults(); repeat (4) tick();

      // fetch buffer fills without consumption, then drains by two
      defaults(); n_cons = 0; repeat (8) tick();
      defaults(); n_cons = 2; repeat (4) tick();

      // flush during WFM with a same-cycle miss, then flush without redirect
      defaults(); n_hit = 1'b0; tick();
      defaults(); tick();
      defaults(); n_hit = 1'b0; n_fl = 1'b1; n_path = 32'h0000_2000; tick();
      defaults(); repeat (2) tick();
      defaults(); n_fl = 1'b1; n_nr = 1'b1; n_path = 32'h0000_3000; tick();
      defaults(); repeat (3) tick();

      // BTB taken at 0x8000_0008, then a single-cycle stall pulse
      defaults(); n_fl = 1'b1; n_path = 32'h8000_0000; tick();
      for (int i = 0; i < 6; i++) begin
         defaults();
         n_bp  = m_req_f && (m_addr_f == 32'h8000_0008);
         n_tgt = 32'h0000_0100;
         tick();
      end
      defaults(); n_stall = 3'b010; tick();
      defaults(); repeat (3) tick();

      // ten stall cycles, then clear together with a stall
      defaults(); n_stall = 3'b001; repeat (10) tick();
      defaults(); n_stall = 3'b001; n_clr = 1'b1; tick();
      defaults(); repeat (2) tick();

      // address wrap past 0xFFFF_FFFC
      defaults(); n_fl = 1'b1; n_path = 32'hFFFF_FFF8; tick();
      defaults(); repeat (5) tick();

      // randomized traffic
      repeat (1200) begin
         defaults();
         n_hit   = ($urandom_range(0, 99) < 85);
         n_mb    = ($urandom_range(0, 99) < 30);
         n_fl    = ($urandom_range(0, 99) < 5);
         n_path  = $urandom & 32'hFFFF_FFFE;
         n_nr    = n_fl ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2);
         n_bp    = ($urandom_range(0, 99) < 10);
         n_tgt   = $urandom & 32'hFFFF_FFFE;
         n_stall = ($urandom_range(0, 99) < 10) ? 3'($urandom_range(1, 7)) : 3'b000;
         n_cons  = $urandom_range(0, MAX_CONSUME);
         n_clr   = ($urandom_range(0, 99) < 3);
         tick();
      end

      defaults(); repeat (3) tick();
      @(negedge clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
